// File: rtl/instr_fetch_prefetch.sv
// Sequential instruction fetcher with a small prefetch FIFO and redirect flush.
// Define PREFETCH_BYPASS_EN to forward a response straight out when the FIFO is empty.
`timescale 1ns/1ps
module instr_fetch_prefetch #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fetch_en_i,
    input  logic [31:0]           boot_addr_i,
    input  logic                  redirect_i,
    input  logic [31:0]           redirect_pc_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wmask_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_rvalid_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_rdata_o,
    output logic [31:0]           instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     tag_pc;
    logic [CW-1:0]   count;
    logic            inflight;
    logic            discard;
    logic            redir_seen;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     fifo_data [DEPTH];
    logic [31:0]     fifo_pc   [DEPTH];

    logic            run;
    logic [CW:0]     credit;
    logic            resp_ok;
    logic            fifo_valid;
    logic            push;
    logic            pop_fifo;

    assign run        = (state == RUN);
    assign credit     = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign mem_req_o  = run && fetch_en_i && !redirect_i
                        && (credit < (CW+1)'(DEPTH));
    assign mem_addr_o = fetch_pc[ADDR_WIDTH+1:2];
    assign mem_we_o    = 1'b0;
    assign mem_wmask_o = 4'h0;
    assign mem_wdata_o = 32'h0;

    // A redirect in the same cycle kills the arriving response.
    assign resp_ok    = mem_rvalid_i && !discard && run && !redirect_i;
    assign fifo_valid = (count != '0);
    assign pop_fifo   = fifo_valid && instr_ready_i;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass        = resp_ok && !fifo_valid;
    assign push          = resp_ok && !(bypass && instr_ready_i);
    assign instr_valid_o = fifo_valid || bypass;
    assign instr_rdata_o = bypass ? mem_rdata_i : fifo_data[rd_ptr];
    assign instr_pc_o    = bypass ? tag_pc : fifo_pc[rd_ptr];
`else
    assign push          = resp_ok;
    assign instr_valid_o = fifo_valid;
    assign instr_rdata_o = fifo_data[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            fetch_pc   <= 32'h0;
            tag_pc     <= 32'h0;
            count      <= '0;
            inflight   <= 1'b0;
            discard    <= 1'b0;
            redir_seen <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= 32'h0;
                fifo_pc[i]   <= 32'h0;
            end
        end else begin
            inflight <= mem_req_o;
            discard  <= redirect_i && inflight;
            if (mem_req_o) begin
                tag_pc <= fetch_pc;
            end
            if (state == IDLE) begin
                if (redirect_i) begin
                    redir_seen <= 1'b1;
                end
                if (fetch_en_i) begin
                    state <= RUN;
                end
            end

            // Boot address only applies if no redirect was seen while idle.
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i & ~32'h3;
            end else if (state == IDLE) begin
                if (fetch_en_i && !redir_seen) begin
                    fetch_pc <= boot_addr_i & ~32'h3;
                end
            end else if (mem_req_o) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (push) begin
                fifo_data[wr_ptr] <= mem_rdata_i;
                fifo_pc[wr_ptr]   <= tag_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop_fifo) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (redirect_i) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else if (push && !pop_fifo) begin
                count <= count + CW'(1);
            end else if (!push && pop_fifo) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
// Scoreboard bench for instr_fetch_prefetch: directed phases, queued expectations.
`timescale 1ns/1ps
module tb_instr_fetch_prefetch;

    localparam int DEPTH = 4;
    localparam int AW    = 12;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          fetch_en = 1'b0;
    logic [31:0]   boot_addr = 32'h0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          ready = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;
    logic          mem_rvalid = 1'b0;
    logic          instr_valid;
    logic [31:0]   instr_rdata;
    logic [31:0]   instr_pc;

    int checks = 0;
    int fails  = 0;
    int nreq   = 0;
    int nxfer  = 0;
    logic [31:0] next_pc = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    instr_fetch_prefetch #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fetch_en_i    (fetch_en),
        .boot_addr_i   (boot_addr),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_we_o      (mem_we),
        .mem_wmask_o   (mem_wmask),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_rvalid_i  (mem_rvalid),
        .instr_valid_o (instr_valid),
        .instr_rdata_o (instr_rdata),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (ready)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h5A00_0000 | {20'h0, a};
    endfunction

    // One-cycle-latency memory
    always @(posedge clk_i) begin
        mem_rvalid <= mem_req;
        mem_rdata  <= mem_word(mem_addr);
        if (mem_req) nreq++;
    end

    // Monitor: every transfer must match the head of the expectation queue
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && instr_valid && ready) begin
            nxfer++;
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected: got pc=%h data=%h, none expected",
                         instr_pc, instr_rdata);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instr_rdata !== e.data) begin
                    fails++;
                    $display("FAIL xfer: got pc=%h data=%h, expected pc=%h data=%h",
                             instr_pc, instr_rdata, e.pc, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{next_pc, mem_word(next_pc[AW+1:2])});
            next_pc = next_pc + 32'd4;
        end
    endtask

    // Hold ready until every queued expectation has been consumed
    task automatic drain;
        ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        ready = 1'b0;
        chk("drain_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset
        repeat (3) tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_rdata", instr_rdata, 0);
        chk("rst_pc", instr_pc, 0);
        chk("wr_consts", {mem_we, mem_wmask, mem_wdata[26:0]}, 0);

        // Boot at 0x100, ready held high
        tick();
        boot_addr = 32'h100;
        fetch_en  = 1'b1;
        ready     = 1'b1;
        next_pc   = 32'h100;
        push_exp(8);
        @(posedge clk_i);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("boot_req", mem_req, 1);
            chk("boot_addr", mem_addr, 32'h40 + k);
            chk("boot_valid", instr_valid, (k >= LAT) ? 1 : 0);
        end
        tick();
        drain();

        // Backpressure: FIFO fills, issue stops
        repeat (10) tick();
        @(negedge clk_i);
        chk("bp_req_low", mem_req, 0);
        chk("bp_buffered", nreq - nxfer, DEPTH);
        tick();
        push_exp(DEPTH + 4);
        drain();

        // fetch_en drop mid-stream
        push_exp(12);
        ready = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("fe_req_before", mem_req, 1);
        tick();
        fetch_en = 1'b0;
        @(negedge clk_i);
        chk("fe_req_stop", mem_req, 0);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        chk("fe_drained", instr_valid, 0);
        tick();
        fetch_en = 1'b1;
        drain();

        // Redirect with a response in flight
        repeat (6) tick();
        push_exp(1);
        drain();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk_i);
        chk("rd_req_blocked", mem_req, 0);
        chk("rd_inflight", mem_rvalid, 1);
        tick();
        redirect = 1'b0;
        @(negedge clk_i);
        chk("rd_req_next", mem_req, 1);
        chk("rd_addr_next", mem_addr, 32'h80);
        chk("rd_valid_r1", instr_valid, 0);
        tick();
        @(negedge clk_i);
        chk("rd_valid_r2", instr_valid, (LAT == 1) ? 1 : 0);
        tick();
        @(negedge clk_i);
        chk("rd_valid_r3", instr_valid, 1);
        chk("rd_pc_r3", instr_pc, 32'h200);
        tick();
        next_pc = 32'h200;
        push_exp(6);
        drain();

        // Redirect + pop with three words buffered, then PC wrap
        repeat (6) tick();
        push_exp(2);
        ready = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk_i);
        chk("rp_req_blocked", mem_req, 0);
        chk("rp_valid_pop", instr_valid, 1);
        tick();
        redirect = 1'b0;
        ready    = 1'b0;
        @(negedge clk_i);
        chk("rp_valid_after", instr_valid, 0);
        chk("rp_popped_once", exp_q.size(), 0);
        chk("wrap_addr", mem_addr, 32'hFFF);
        tick();
        next_pc = 32'hFFFF_FFFC;
        push_exp(6);
        drain();

        // Reset mid-operation, then redirect while idle overrides boot
        repeat (4) tick();
        rst_i    = 1'b1;
        fetch_en = 1'b0;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst2_req", mem_req, 0);
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_pc", instr_pc, 0);
        chk("rst2_rdata", instr_rdata, 0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h301;
        @(negedge clk_i);
        chk("idle_req", mem_req, 0);
        tick();
        redirect  = 1'b0;
        fetch_en  = 1'b1;
        boot_addr = 32'h100;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("idle_redir_addr", mem_addr, 32'hC0);
        chk("idle_redir_req", mem_req, 1);
        tick();
        next_pc = 32'h300;
        push_exp(6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
